rca_digit_serial: RTL

- Parametrised, multi-cycle successor to our 4-bit ripple-carry adder.
- Adds or subtracts two WIDTH-bit operands DIGIT bits per clock, LSB digit first, carrying between digits in a register.
- Uses a start/busy/done handshake and reports carry-out and signed overflow.
- Sits beside datapath blocks that trade latency for a short carry chain.

---
 rtl/rca_pkg.sv | 11 +
 rtl/rca_digit.sv | 30 +++
 rtl/rca_digit_serial.sv | 133 +++++++++++++
 3 files changed

// File: rtl/rca_pkg.sv
// Shared types and sizing helpers for the digit-serial ripple-carry adder.
package rca_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Width of the digit index counter; never narrower than one bit.
    function automatic int idx_w(input int ndig);
        return (ndig > 1) ? $clog2(ndig) : 1;
    endfunction

endpackage

// File: rtl/rca_digit.sv
// Combinational DIGIT-bit ripple adder made of full-adder cells; also exposes
// the carry into the top bit so the caller can derive signed overflow.
module rca_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    logic [DIGIT:0] c;

    // One full-adder cell per bit, chained through c.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout  = c[DIGIT];
    assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/rca_digit_serial.sv
// Multi-cycle add/subtract: one DIGIT-wide ripple per clock, LSB digit first,
// with the inter-digit carry held in a register and a start/busy/done handshake.
module rca_digit_serial
    import rca_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int IW   = idx_w(NDIG);
    localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] bx_q, bx_d;
    logic             c_q, c_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [DIGIT-1:0] dig_a, dig_b, dig_s;
    logic             dig_cout, dig_c_msb;

    assign dig_a = a_q[idx_q*DIGIT +: DIGIT];
    assign dig_b = bx_q[idx_q*DIGIT +: DIGIT];

    rca_digit #(.DIGIT(DIGIT)) u_digit (
        .a     (dig_a),
        .b     (dig_b),
        .cin   (c_q),
        .s     (dig_s),
        .cout  (dig_cout),
        .c_msb (dig_c_msb)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        bx_d    = bx_q;
        c_d     = c_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            RUN: begin
                res_d[idx_q*DIGIT +: DIGIT] = dig_s;
                c_d = dig_cout;
                if (idx_q == LAST) begin
                    // Publish results only here, so outputs never show partial sums.
                    idx_d   = '0;
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    sum_d   = res_d;
                    cout_d  = dig_cout;
                    ovf_d   = dig_c_msb ^ dig_cout;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                // IDLE and DONE both accept a new request.
                if (start) begin
                    a_d     = a;
                    bx_d    = sub ? ~b : b;
                    c_d     = sub ? ~cin : cin;
                    idx_d   = '0;
                    state_d = RUN;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            bx_q    <= '0;
            c_q     <= 1'b0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            bx_q    <= bx_d;
            c_q     <= c_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
